// File: rtl/cpu_regfile8_if.sv
// Register-file request/response bundle between the load/ALU decoder and cpu_regfile8.
interface cpu_regfile8_if;
   logic        ce;
   logic [2:0]  rd_a_sel;
   logic [7:0]  rd_a_data;
   logic [2:0]  rd_b_sel;
   logic [7:0]  rd_b_data;
   logic        wr8_en;
   logic [2:0]  wr8_sel;
   logic [7:0]  wr8_data;
   logic        wr16_en;
   logic [2:0]  wr16_sel;
   logic [15:0] wr16_data;
   logic [3:0]  f_wr_mask;
   logic [3:0]  f_wr_data;
   logic [1:0]  sp_step;
   logic [1:0]  hl_step;
   logic        sel_err;
   logic [7:0]  reg_a, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l, reg_f;
   logic [15:0] reg_sp;

   modport master (
      output ce, rd_a_sel, rd_b_sel, wr8_en, wr8_sel, wr8_data,
             wr16_en, wr16_sel, wr16_data, f_wr_mask, f_wr_data, sp_step, hl_step,
      input  rd_a_data, rd_b_data, sel_err,
             reg_a, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l, reg_f, reg_sp
   );

   modport slave (
      input  ce, rd_a_sel, rd_b_sel, wr8_en, wr8_sel, wr8_data,
             wr16_en, wr16_sel, wr16_data, f_wr_mask, f_wr_data, sp_step, hl_step,
      output rd_a_data, rd_b_data, sel_err,
             reg_a, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l, reg_f, reg_sp
   );
endinterface

// File: rtl/cpu_regfile8.sv
// 8-bit CPU register file (B,C,D,E,H,L,A,F,SP) with two combinational read ports,
// byte/pair writes, flag-masked updates and SP/HL increment/decrement.
module cpu_regfile8 #(
   parameter logic [15:0] RESET_AF = 16'h0000,
   parameter logic [15:0] RESET_BC = 16'h0000,
   parameter logic [15:0] RESET_DE = 16'h0000,
   parameter logic [15:0] RESET_HL = 16'h0000,
   parameter logic [15:0] RESET_SP = 16'h0000
) (
   input  logic          clk,
   input  logic          reset,
   cpu_regfile8_if.slave bus
);
   localparam int unsigned W8  = 8;
   localparam int unsigned W16 = 16;
   localparam int unsigned WF  = 4;

   logic [W8-1:0]  b_q, c_q, d_q, e_q, h_q, l_q, a_q;
   logic [W8-1:0]  b_d, c_d, d_d, e_d, h_d, l_d, a_d;
   logic [WF-1:0]  f_q, f_d;            // upper flag nibble Z,N,H,C
   logic [W16-1:0] sp_q, sp_d;
   logic           sel_err_q, sel_err_d;
   logic           hl_hold, sp_hold;
   logic [W16-1:0] hl_cur;

   assign hl_cur = {h_q, l_q};

   // Step suppression: a pair write or a byte write into H/L cancels the pair step
   assign hl_hold = (bus.wr16_en && bus.wr16_sel == 3'd2) ||
                    (bus.wr8_en && (bus.wr8_sel == 3'd4 || bus.wr8_sel == 3'd5));
   assign sp_hold = bus.wr16_en && bus.wr16_sel == 3'd3;

   // Next state: sources applied lowest priority first so higher ones overwrite per byte
   always_comb begin
      b_d = b_q; c_d = c_q; d_d = d_q; e_d = e_q;
      h_d = h_q; l_d = l_q; a_d = a_q; f_d = f_q;
      sp_d = sp_q;
      sel_err_d = sel_err_q;
      if (bus.ce) begin
         for (int i = 0; i < int'(WF); i++) begin
            if (bus.f_wr_mask[i]) f_d[i] = bus.f_wr_data[i];
         end
         if (!hl_hold) begin
            case (bus.hl_step)
               2'b01:   {h_d, l_d} = W16'(hl_cur + 16'd1);
               2'b10:   {h_d, l_d} = W16'(hl_cur - 16'd1);
               default: ;
            endcase
         end
         if (!sp_hold) begin
            case (bus.sp_step)
               2'b01:   sp_d = W16'(sp_q + 16'd1);
               2'b10:   sp_d = W16'(sp_q - 16'd1);
               default: ;
            endcase
         end
         if (bus.wr16_en) begin
            case (bus.wr16_sel)
               3'd0:    {b_d, c_d} = bus.wr16_data;
               3'd1:    {d_d, e_d} = bus.wr16_data;
               3'd2:    {h_d, l_d} = bus.wr16_data;
               3'd3:    sp_d = bus.wr16_data;
               3'd4: begin
                  a_d = bus.wr16_data[15:8];
                  f_d = bus.wr16_data[7:4];
               end
               default: ;
            endcase
         end
         if (bus.wr8_en) begin
            case (bus.wr8_sel)
               3'd0:    b_d = bus.wr8_data;
               3'd1:    c_d = bus.wr8_data;
               3'd2:    d_d = bus.wr8_data;
               3'd3:    e_d = bus.wr8_data;
               3'd4:    h_d = bus.wr8_data;
               3'd5:    l_d = bus.wr8_data;
               3'd7:    a_d = bus.wr8_data;
               default: ;
            endcase
         end
         sel_err_d = bus.wr8_en && bus.wr8_sel == 3'd6;
      end
   end

   // Register state with asynchronous reset to parameterised values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {b_q, c_q} <= RESET_BC;
         {d_q, e_q} <= RESET_DE;
         {h_q, l_q} <= RESET_HL;
         a_q        <= RESET_AF[15:8];
         f_q        <= RESET_AF[7:4];
         sp_q       <= RESET_SP;
         sel_err_q  <= 1'b0;
      end else begin
         b_q <= b_d; c_q <= c_d; d_q <= d_d; e_q <= e_d;
         h_q <= h_d; l_q <= l_d; a_q <= a_d; f_q <= f_d;
         sp_q      <= sp_d;
         sel_err_q <= sel_err_d;
      end
   end

   // Read port A mux; index 6 ((HL) operand) is not a register and reads all-ones
   always_comb begin
      case (bus.rd_a_sel)
         3'd0:    bus.rd_a_data = b_q;
         3'd1:    bus.rd_a_data = c_q;
         3'd2:    bus.rd_a_data = d_q;
         3'd3:    bus.rd_a_data = e_q;
         3'd4:    bus.rd_a_data = h_q;
         3'd5:    bus.rd_a_data = l_q;
         3'd7:    bus.rd_a_data = a_q;
         default: bus.rd_a_data = 8'hFF;
      endcase
   end

   // Read port B mux, same decode as port A
   always_comb begin
      case (bus.rd_b_sel)
         3'd0:    bus.rd_b_data = b_q;
         3'd1:    bus.rd_b_data = c_q;
         3'd2:    bus.rd_b_data = d_q;
         3'd3:    bus.rd_b_data = e_q;
         3'd4:    bus.rd_b_data = h_q;
         3'd5:    bus.rd_b_data = l_q;
         3'd7:    bus.rd_b_data = a_q;
         default: bus.rd_b_data = 8'hFF;
      endcase
   end

   assign bus.reg_a   = a_q;
   assign bus.reg_b   = b_q;
   assign bus.reg_c   = c_q;
   assign bus.reg_d   = d_q;
   assign bus.reg_e   = e_q;
   assign bus.reg_h   = h_q;
   assign bus.reg_l   = l_q;
   assign bus.reg_f   = {f_q, 4'h0};
   assign bus.reg_sp  = sp_q;
   assign bus.sel_err = sel_err_q;
endmodule
